game_round_sequencer: RTL and testbench
=======================================

# game_round_sequencer

Round controller for the quadrant-guessing game. Generates the 4-bit `step` sequence and the pseudo-random target quadrant, and latches the player's quadrant selection. These are the inputs the downstream selection comparator consumes. The block samples the comparator's registered `finish`/`win` verdict to keep a win-streak score and returns to idle after a result hold.

## Interface
- `SHOW_CYCLES`, default 25_000_000: cycles the target quadrant is displayed (0.5 s at 50 MHz).
- `SEL_TIMEOUT`, default 250_000_000: cycles allowed for a selection before a forced loss.
- `RESULT_CYCLES`, default 50_000_000: cycles the result step is held.
- `NUM_QUAD`, default 4: number of legal quadrants; legal range 4..8; codes are 0..NUM_QUAD-1.
- `LFSR_SEED`, default 16'hACE1: LFSR reset value; must be nonzero.
- `clk` in 1: single system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse from the debounced start button.
- `sel_valid` in 1: one-cycle pulse; the player has chosen a quadrant.
- `sel_quad` in 3: the chosen quadrant code.
- `finish` in 1: comparator verdict, loss.
- `win` in 1: comparator verdict, win.
- `step` out 4: current round step code.
- `cuadranterandom` out 3: target quadrant.
- `icuadrante` out 3: latched player quadrant.
- `show_en` out 1: high while the target is to be drawn by the VGA layer.
- `score` out 8: consecutive wins; saturates at 255.
- `busy` out 1: high in any step other than IDLE.

## Operation
- **LFSR**
  - 16-bit Galois LFSR, mask 16'hB400.
  - Advances every cycle from reset, including while idle, so start timing adds entropy.
- **Step codes and transitions**
  - **IDLE = 0.** Waits for `start`. While here, `start` moves the block to ARM.
  - **ARM = 1.** Lasts one cycle.
    - `cuadranterandom` takes `lfsr[2:0]`; if that value ≥ NUM_QUAD, it takes `lfsr[2:0]`−NUM_QUAD instead.
    - `icuadrante` is cleared to 0.
  - **SHOW = 2.** Holds for SHOW_CYCLES cycles with `show_en`=1.
  - **WAIT_SEL = 5.**
    - An accepted selection latches `sel_quad` into `icuadrante` and moves to COMPARE.
    - A selection is accepted only when `sel_valid`=1 and `sel_quad` < NUM_QUAD. Illegal codes are ignored and the block stays waiting.
    - If SEL_TIMEOUT cycles pass with no accepted selection, `icuadrante` is forced to (`cuadranterandom`+1) mod NUM_QUAD, which guarantees a loss, and the block moves to COMPARE.
  - **COMPARE = 7.** Held for exactly 2 cycles, covering the comparator's two-register latency.
  - **RESULT = 8.** Held for RESULT_CYCLES cycles, then returns to IDLE.
    - On the first RESULT cycle, `win` and `finish` are sampled.
    - `win`=1: `score` increments, saturating at 255.
    - `finish`=1: `score` clears to 0.
    - Both 0 (comparator fault): `score` is unchanged.
- **Ignored and edge inputs**
  - `start` outside IDLE is ignored.
  - `sel_valid` outside WAIT_SEL is ignored.
  - `sel_valid` arriving in the same cycle as the timeout expiry: the selection wins.
  - Unused step codes 3, 4, 6 and 9..15 must never appear. If the state register reaches one, it recovers to IDLE on the next cycle.

## Timing
- **Reset values:**
  - `step`=0, `cuadranterandom`=0, `icuadrante`=0.
  - `show_en`=0, `score`=0, `busy`=0.
  - LFSR = LFSR_SEED; cycle counter = 0.
- All outputs are registered and change only on `clk` rising edges.
- `start` sampled at edge N: `step`=1 after edge N+1, `step`=2 after edge N+2.
- SHOW ends after exactly SHOW_CYCLES cycles at `step`=2.
- Accepted `sel_valid` at edge M:
  - `icuadrante` valid and `step`=7 after edge M.
  - `step`=8 after edge M+2.
- Reset asserted mid-round: immediate return to IDLE values. `score` is lost.
- A single down-counter, sized for the largest parameter, is reloaded on every step entry.

## Structure
- Package `game_pkg` holds:
  - the step-code enum `step_t` (IDLE, ARM, SHOW, WAIT_SEL, COMPARE, RESULT with the codes above);
  - the constants `STEP_W`=4 and `QUAD_W`=3;
  - `LFSR_MASK`.
- The comparator shares `game_pkg` for its step-7 decode.
- Sub-module `lfsr16`: clk, rst_n, seed parameter, 16-bit state output. It is reusable for future random events.
- The FSM and counter stay in `game_round_sequencer`.

## Test plan
Benches run with SHOW_CYCLES=4, SEL_TIMEOUT=10, RESULT_CYCLES=3 and the comparator instantiated downstream.
- **Full round.** `start` pulse, then after SHOW `sel_quad` equal to `cuadranterandom`. Required:
  - `step` sequence 0,1,2×4,5…,7,7,8×3,0;
  - `show_en` high for exactly 4 cycles;
  - `win`=1 seen in RESULT; `score`=1.
- **Streak.** Three winning rounds then one wrong pick. Required: `score` 1,2,3, then 0 after the loss.
- **Timeout.** No `sel_valid`. Required:
  - after 10 WAIT_SEL cycles, `icuadrante`=(`cuadranterandom`+1)%4;
  - `finish`=1; `score`=0.
- **Illegal and early selections.**
  - With NUM_QUAD=5, `sel_quad`=6 in WAIT_SEL is ignored and the block stays in step 5.
  - `sel_valid` during SHOW is ignored.
  - `start` during SHOW is ignored.
- **Reset mid-operation.** `rst_n` pulsed low during COMPARE. Required: all outputs at their reset values immediately; the next `start` yields the same `cuadranterandom` as a fresh-reset run with identical start timing.
- **Range sweep.** 1000 rounds with NUM_QUAD=5 and randomized start delays. Required: `cuadranterandom` < 5 on every round and every value 0..4 observed.

Source files
------------

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared types and constants for the quadrant-guessing game
// Purpose: step-code enum, field widths, LFSR tap mask and quadrant helpers.
//          Shared by the round sequencer and the downstream comparator.
// Ports:   none (package).
package game_pkg;

  localparam int STEP_W = 4;
  localparam int QUAD_W = 3;
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  typedef enum logic [STEP_W-1:0] {
    IDLE     = 4'd0,
    ARM      = 4'd1,
    SHOW     = 4'd2,
    WAIT_SEL = 4'd5,
    COMPARE  = 4'd7,
    RESULT   = 4'd8
  } step_t;

  // Map a raw LFSR value into 0..nq-1. Only the low three bits are used;
  // with nq in 4..8 a single subtraction is always enough.
  function automatic logic [QUAD_W-1:0] fold_quad(input logic [15:0] raw,
                                                  input int unsigned nq);
    logic [QUAD_W-1:0] low;
    low = raw[QUAD_W-1:0];
    if (32'(low) >= nq) fold_quad = QUAD_W'(32'(low) - nq);
    else                fold_quad = low;
  endfunction

  // (cur + 1) mod nq: always differs from cur, used to force a loss.
  function automatic logic [QUAD_W-1:0] next_quad(input logic [QUAD_W-1:0] cur,
                                                  input int unsigned nq);
    if (32'(cur) + 32'd1 >= nq) next_quad = '0;
    else                        next_quad = cur + 1'b1;
  endfunction

endpackage

// File: rtl/game_round_sequencer_if.sv
// rtl/game_round_sequencer_if.sv - player/comparator bus of the round sequencer
// Purpose: bundles the button, selection, verdict and round-state signals.
// Modports: slave  - the sequencer (inputs start/sel/verdict, drives step etc.)
//           master - the environment (buttons, comparator, VGA layer)
interface game_round_sequencer_if;
  import game_pkg::*;

  logic              start;
  logic              sel_valid;
  logic [QUAD_W-1:0] sel_quad;
  logic              finish;
  logic              win;
  logic [STEP_W-1:0] step;
  logic [QUAD_W-1:0] cuadranterandom;
  logic [QUAD_W-1:0] icuadrante;
  logic              show_en;
  logic [7:0]        score;
  logic              busy;

  modport slave (
    input  start, sel_valid, sel_quad, finish, win,
    output step, cuadranterandom, icuadrante, show_en, score, busy
  );

  modport master (
    output start, sel_valid, sel_quad, finish, win,
    input  step, cuadranterandom, icuadrante, show_en, score, busy
  );

endinterface

// File: rtl/lfsr16.sv
// rtl/lfsr16.sv - free-running 16-bit Galois LFSR
// Purpose: pseudo-random source, advances every clock from reset.
// Ports:   clk, rst_n (async active-low), o_state (current 16-bit state).
module lfsr16
  import game_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1  // must be nonzero
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] o_state
);

  logic [15:0] r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SEED;
    end else begin
      r_state <= {1'b0, r_state[15:1]} ^ (r_state[0] ? LFSR_MASK : 16'h0000);
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/game_round_sequencer.sv
// rtl/game_round_sequencer.sv - round controller for the quadrant-guessing game
// Purpose: steps IDLE->ARM->SHOW->WAIT_SEL->COMPARE->RESULT, picks the target
//          quadrant, latches the player's pick and keeps a win-streak score.
// Ports:   clk, rst_n (async active-low),
//          bus (slave): start, sel_valid, sel_quad, finish, win in;
//                       step, cuadranterandom, icuadrante, show_en, score, busy out.
module game_round_sequencer
  import game_pkg::*;
#(
  parameter int unsigned   SHOW_CYCLES   = 25_000_000,
  parameter int unsigned   SEL_TIMEOUT   = 250_000_000,
  parameter int unsigned   RESULT_CYCLES = 50_000_000,
  parameter int unsigned   NUM_QUAD      = 4,
  parameter logic [15:0]   LFSR_SEED     = 16'hACE1
) (
  input logic                   clk,
  input logic                   rst_n,
  game_round_sequencer_if.slave bus
);

  localparam int unsigned MAX_A   = (SHOW_CYCLES > SEL_TIMEOUT) ? SHOW_CYCLES : SEL_TIMEOUT;
  localparam int unsigned MAX_CYC = (MAX_A > RESULT_CYCLES) ? MAX_A : RESULT_CYCLES;
  localparam int          CNT_W   = $clog2(MAX_CYC + 1);

  step_t             r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_start;
  logic              r_first;
  logic              r_show_en;
  logic              r_busy;
  logic [QUAD_W-1:0] r_crand;
  logic [QUAD_W-1:0] r_icuad;
  logic [7:0]        r_score;

  logic [15:0]       w_lfsr;
  logic              w_sel_ok;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .o_state (w_lfsr)
  );

  assign w_sel_ok = bus.sel_valid && (32'(bus.sel_quad) < NUM_QUAD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_start   <= 1'b0;
      r_first   <= 1'b0;
      r_show_en <= 1'b0;
      r_busy    <= 1'b0;
      r_crand   <= '0;
      r_icuad   <= '0;
      r_score   <= '0;
    end else begin
      // start is registered, and only captured while idle so a press during
      // a round is never replayed once the round ends.
      r_start <= (r_state == IDLE) && !r_start && bus.start;
      r_first <= 1'b0;

      case (r_state)
        IDLE: begin
          if (r_start) begin
            r_state <= ARM;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
          end
        end

        ARM: begin
          r_crand   <= fold_quad(w_lfsr, NUM_QUAD);
          r_icuad   <= '0;
          r_state   <= SHOW;
          r_show_en <= 1'b1;
          r_cnt     <= CNT_W'(SHOW_CYCLES - 1);
        end

        SHOW: begin
          if (r_cnt == '0) begin
            r_state   <= WAIT_SEL;
            r_show_en <= 1'b0;
            r_cnt     <= CNT_W'(SEL_TIMEOUT - 1);
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        WAIT_SEL: begin
          // A legal selection takes priority over a same-cycle timeout.
          if (w_sel_ok) begin
            r_icuad <= bus.sel_quad;
            r_state <= COMPARE;
            r_cnt   <= CNT_W'(1);
          end else if (r_cnt == '0) begin
            r_icuad <= next_quad(r_crand, NUM_QUAD);
            r_state <= COMPARE;
            r_cnt   <= CNT_W'(1);
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        COMPARE: begin
          if (r_cnt == '0) begin
            r_state <= RESULT;
            r_first <= 1'b1;
            r_cnt   <= CNT_W'(RESULT_CYCLES - 1);
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        RESULT: begin
          // Verdict is valid on the first RESULT cycle; neither flag set
          // means the comparator misbehaved, so the streak is left alone.
          if (r_first) begin
            if (bus.win) begin
              if (r_score != 8'hFF) r_score <= r_score + 8'd1;
            end else if (bus.finish) begin
              r_score <= '0;
            end
          end
          if (r_cnt == '0) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        default: begin
          r_state   <= IDLE;
          r_busy    <= 1'b0;
          r_show_en <= 1'b0;
          r_cnt     <= '0;
        end
      endcase
    end
  end

  assign bus.step            = r_state;
  assign bus.cuadranterandom = r_crand;
  assign bus.icuadrante      = r_icuad;
  assign bus.show_en         = r_show_en;
  assign bus.score           = r_score;
  assign bus.busy            = r_busy;

endmodule

// File: tb/tb_game_round_sequencer.sv
// tb/tb_game_round_sequencer.sv - self-checking bench for game_round_sequencer
module tb_game_round_sequencer;
  import game_pkg::*;

  localparam int          NQ   = 5;
  localparam int          SHOW = 4;
  localparam int          TO   = 10;
  localparam int          RES  = 3;
  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  game_round_sequencer_if bus ();

  game_round_sequencer #(
    .SHOW_CYCLES   (SHOW),
    .SEL_TIMEOUT   (TO),
    .RESULT_CYCLES (RES),
    .NUM_QUAD      (NQ),
    .LFSR_SEED     (SEED)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Downstream comparator: two register stages behind step 7.
  logic c_v1, c_m1, comp_kill;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_v1 <= 1'b0; c_m1 <= 1'b0; bus.win <= 1'b0; bus.finish <= 1'b0;
    end else begin
      c_v1       <= (bus.step == 4'd7);
      c_m1       <= (bus.icuadrante == bus.cuadranterandom);
      bus.win    <= c_v1 & c_m1 & !comp_kill;
      bus.finish <= c_v1 & !c_m1 & !comp_kill;
    end
  end

  // Independent LFSR model: expected target captured on the ARM cycle.
  logic [15:0] m_lfsr;
  logic [2:0]  m_exp_cr;

  function automatic logic [2:0] fold_m(input logic [15:0] v);
    int x;
    x = int'(v & 16'h0007);
    if (x >= NQ) x = x - NQ;
    return 3'(x);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_lfsr   <= SEED;
      m_exp_cr <= 3'd0;
    end else begin
      if (bus.step == 4'd1) m_exp_cr <= fold_m(m_lfsr);
      m_lfsr <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic wait_step(input logic [3:0] s, input int budget, input string nm);
    int k = 0;
    while (bus.step !== s && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (bus.step !== s) chk({nm, "_timeout"}, 32'(bus.step), 32'(s));
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic pick(input int q);
    bus.sel_valid = 1'b1;
    bus.sel_quad  = 3'(q);
    @(negedge clk);
    bus.sel_valid = 1'b0;
    bus.sel_quad  = 3'd0;
  endtask

  // mode: 0 = correct pick, 1 = wrong pick, 2 = illegal code then correct, 3 = timeout
  typedef struct {
    int dly;
    int mode;
    bit fault;
    int exp_win;
    int exp_fin;
    int exp_score;
  } rec_t;

  task automatic do_round(input int dly, input int mode, input bit fault,
                          output int exp_icuad, output int w, output int f);
    int cr;
    int n5;
    repeat (dly) @(negedge clk);
    comp_kill = fault;
    pulse_start();
    wait_step(4'd5, 20, "row_wait_sel");
    cr = int'(bus.cuadranterandom);
    exp_icuad = cr;
    case (mode)
      0: pick(cr);
      1: begin exp_icuad = (cr + 1) % NQ; pick(exp_icuad); end
      2: begin
        pick(6);
        chk("illegal_sel_step", 32'(bus.step), 32'd5);
        chk("illegal_sel_icuad", 32'(bus.icuadrante), 32'd0);
        pick(cr);
      end
      default: begin
        exp_icuad = (cr + 1) % NQ;
        n5 = 0;
        while (bus.step == 4'd5 && n5 < 40) begin
          n5++;
          @(negedge clk);
        end
        chk("timeout_wait_cycles", 32'(n5), 32'(TO));
      end
    endcase
    wait_step(4'd8, 10, "row_result");
    w = int'(bus.win);
    f = int'(bus.finish);
    wait_step(4'd0, 20, "row_idle");
    comp_kill = 1'b0;
  endtask

  rec_t tbl[8];
  int   exp_tr[13];

  initial begin
    int cr, cr_a, nshow, ei, w, f, d;
    logic [7:0] seen;

    tbl[0] = '{dly: 3, mode: 0, fault: 0, exp_win: 1, exp_fin: 0, exp_score: 2};
    tbl[1] = '{dly: 5, mode: 0, fault: 0, exp_win: 1, exp_fin: 0, exp_score: 3};
    tbl[2] = '{dly: 1, mode: 1, fault: 0, exp_win: 0, exp_fin: 1, exp_score: 0};
    tbl[3] = '{dly: 2, mode: 2, fault: 0, exp_win: 1, exp_fin: 0, exp_score: 1};
    tbl[4] = '{dly: 0, mode: 3, fault: 0, exp_win: 0, exp_fin: 1, exp_score: 0};
    tbl[5] = '{dly: 4, mode: 0, fault: 0, exp_win: 1, exp_fin: 0, exp_score: 1};
    tbl[6] = '{dly: 2, mode: 0, fault: 1, exp_win: 0, exp_fin: 0, exp_score: 1};
    tbl[7] = '{dly: 7, mode: 0, fault: 0, exp_win: 1, exp_fin: 0, exp_score: 2};
    exp_tr = '{0, 1, 2, 2, 2, 2, 5, 7, 7, 8, 8, 8, 0};

    bus.start = 1'b0; bus.sel_valid = 1'b0; bus.sel_quad = 3'd0; comp_kill = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_step",  32'(bus.step), 32'd0);
    chk("rst_cr",    32'(bus.cuadranterandom), 32'd0);
    chk("rst_icuad", 32'(bus.icuadrante), 32'd0);
    chk("rst_show",  32'(bus.show_en), 32'd0);
    chk("rst_score", 32'(bus.score), 32'd0);
    chk("rst_busy",  32'(bus.busy), 32'd0);
    rst_n = 1'b1;

    // Full round, exact step trace
    nshow = 0;
    pulse_start();
    for (int i = 0; i < 13; i++) begin
      chk($sformatf("trace_step[%0d]", i), 32'(bus.step), 32'(exp_tr[i]));
      if (bus.show_en) nshow++;
      if (i == 9) chk("trace_win", 32'(bus.win), 32'd1);
      if (i == 6) chk("trace_busy", 32'(bus.busy), 32'd1);
      if (i == 12) chk("trace_idle_busy", 32'(bus.busy), 32'd0);
      if (i == 6) begin
        bus.sel_valid = 1'b1;
        bus.sel_quad  = bus.cuadranterandom;
      end else begin
        bus.sel_valid = 1'b0;
      end
      @(negedge clk);
    end
    chk("trace_show_cycles", 32'(nshow), 32'd4);
    chk("trace_score", 32'(bus.score), 32'd1);
    chk("trace_cr_model", 32'(bus.cuadranterandom), 32'(m_exp_cr));
    chk("trace_icuad", 32'(bus.icuadrante), 32'(bus.cuadranterandom));

    // Table-driven rounds
    for (int r = 0; r < 8; r++) begin
      do_round(tbl[r].dly, tbl[r].mode, tbl[r].fault, ei, w, f);
      chk($sformatf("row%0d_cr", r), 32'(bus.cuadranterandom), 32'(m_exp_cr));
      chk($sformatf("row%0d_icuad", r), 32'(bus.icuadrante), 32'(ei));
      chk($sformatf("row%0d_win", r), 32'(w), 32'(tbl[r].exp_win));
      chk($sformatf("row%0d_finish", r), 32'(f), 32'(tbl[r].exp_fin));
      chk($sformatf("row%0d_score", r), 32'(bus.score), 32'(tbl[r].exp_score));
    end

    // start and sel_valid during SHOW are ignored
    pulse_start();
    wait_step(4'd2, 5, "show_reach");
    cr = int'(bus.cuadranterandom);
    bus.start = 1'b1; bus.sel_valid = 1'b1; bus.sel_quad = 3'(cr);
    @(negedge clk);
    bus.start = 1'b0; bus.sel_valid = 1'b0; bus.sel_quad = 3'd0;
    chk("show_ignores_inputs", 32'(bus.step), 32'd2);
    wait_step(4'd5, 10, "show_to_wait");
    chk("show_sel_not_latched", 32'(bus.icuadrante), 32'd0);
    pick(cr);
    wait_step(4'd0, 20, "show_round_end");
    repeat (3) @(negedge clk);
    chk("start_in_show_ignored", 32'(bus.step), 32'd0);
    chk("show_round_score", 32'(bus.score), 32'd3);

    // Selection on the timeout-expiry cycle wins
    pulse_start();
    wait_step(4'd5, 20, "edge_wait");
    cr = int'(bus.cuadranterandom);
    repeat (TO - 1) @(negedge clk);
    chk("edge_still_waiting", 32'(bus.step), 32'd5);
    pick(cr);
    chk("edge_sel_beats_timeout", 32'(bus.icuadrante), 32'(cr));
    chk("edge_step_compare", 32'(bus.step), 32'd7);
    wait_step(4'd0, 20, "edge_round_end");
    chk("edge_score", 32'(bus.score), 32'd4);

    // Reset during COMPARE, then replay with identical start timing
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    pulse_start();
    wait_step(4'd5, 20, "rst_a_wait");
    cr_a = int'(bus.cuadranterandom);
    pick(cr_a);
    chk("rst_in_compare", 32'(bus.step), 32'd7);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_step",  32'(bus.step), 32'd0);
    chk("mid_rst_cr",    32'(bus.cuadranterandom), 32'd0);
    chk("mid_rst_icuad", 32'(bus.icuadrante), 32'd0);
    chk("mid_rst_show",  32'(bus.show_en), 32'd0);
    chk("mid_rst_score", 32'(bus.score), 32'd0);
    chk("mid_rst_busy",  32'(bus.busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    pulse_start();
    wait_step(4'd5, 20, "rst_b_wait");
    chk("rst_replay_cr", 32'(bus.cuadranterandom), 32'(cr_a));
    chk("rst_replay_model", 32'(bus.cuadranterandom), 32'(m_exp_cr));
    pick(int'(bus.cuadranterandom));
    wait_step(4'd0, 20, "rst_b_end");
    chk("rst_replay_score", 32'(bus.score), 32'd1);

    // Range sweep with random start delays; streak saturates at 255
    seen = 8'h00;
    for (int r = 0; r < 1000; r++) begin
      d = int'($urandom_range(0, 7));
      repeat (d) @(negedge clk);
      pulse_start();
      wait_step(4'd5, 20, "sweep_wait");
      cr = int'(bus.cuadranterandom);
      chk("sweep_cr_range", 32'(cr < NQ), 32'd1);
      chk("sweep_cr_model", 32'(cr), 32'(m_exp_cr));
      seen[cr[2:0]] = 1'b1;
      pick(cr);
      wait_step(4'd0, 20, "sweep_end");
    end
    chk("sweep_all_values_seen", 32'(seen), 32'h1F);
    chk("score_saturates", 32'(bus.score), 32'd255);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
